// File: rtl/lc3_dmem_pkg.sv
// Shared types and helpers for the LC3 data-memory controller.
// Holds the controller state encoding, the latched request record and the range check.
package lc3_dmem_pkg;

  localparam int WORD_W = 16;
  localparam int ADDR_W = 16;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACCESS  = 2'd1,
    WAIT    = 2'd2,
    CAPTURE = 2'd3
  } state_t;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [WORD_W-1:0] din;
    logic              rd;
  } dmem_req_t;

  // Any set address bit at or above the implemented width puts the access out of range.
  function automatic logic addr_out_of_range(input logic [ADDR_W-1:0] addr,
                                             input int             addr_w_eff);
    logic oor;
    oor = 1'b0;
    for (int i = 0; i < ADDR_W; i++) begin
      if ((i >= addr_w_eff) && addr[i]) oor = 1'b1;
    end
    return oor;
  endfunction

endpackage

// File: rtl/lc3_dmem_wait_cnt.sv
// 4-bit loadable down-counter that times the SRAM wait states.
// Load has priority over enable; the count rests at zero.
module lc3_dmem_wait_cnt (
  input  logic       clock,
  input  logic       reset,
  input  logic       i_load,
  input  logic [3:0] i_load_val,
  input  logic       i_en,
  output logic       o_zero
);

  logic [3:0] r_cnt;

  // NOTE: sequential state is updated with non-blocking assignments only.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_cnt <= 4'd0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (i_en && (r_cnt != 4'd0)) begin
      r_cnt <= r_cnt - 4'd1;
    end
  end

  assign o_zero = (r_cnt == 4'd0);

endmodule

// File: rtl/lc3_dmem_ctrl.sv
// Data-memory controller behind the LC3 MemAccess stage: one access at a time,
// sequenced onto a synchronous SRAM with WAIT_CYCLES extra wait states.
module lc3_dmem_ctrl
  import lc3_dmem_pkg::*;
#(
  parameter int WAIT_CYCLES = 0,
  parameter int ADDR_W_EFF  = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] dmem_addr,
  input  logic [WORD_W-1:0] dmem_din,
  input  logic              dmem_rd,
  output logic              rsp_valid,
  output logic [WORD_W-1:0] rsp_data,
  output logic              rsp_err,
  output logic              complete_data,
  output logic              sram_ce,
  output logic              sram_we,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [WORD_W-1:0] sram_wdata,
  input  logic [WORD_W-1:0] sram_rdata
);

  localparam logic [3:0] CNT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  state_t      r_state;
  state_t      w_next_state;
  dmem_req_t   r_req;
  dmem_req_t   w_req_in;
  logic        r_err;
  logic        w_err_in;
  logic        w_accept;
  logic        w_cnt_zero;

  logic              r_req_ready;
  logic              r_rsp_valid;
  logic              r_rsp_err;
  logic [WORD_W-1:0] r_rsp_data;
  logic              r_sram_ce;
  logic              r_sram_we;

  logic              w_req_ready_d;
  logic              w_rsp_valid_d;
  logic              w_rsp_err_d;
  logic [WORD_W-1:0] w_rsp_data_d;
  logic              w_sram_ce_d;
  logic              w_sram_we_d;

  assign w_req_in = '{addr: dmem_addr, din: dmem_din, rd: dmem_rd};
  assign w_err_in = addr_out_of_range(dmem_addr, ADDR_W_EFF);
  // req_ready is high exactly while IDLE, so it doubles as the accept qualifier.
  assign w_accept = req_valid & r_req_ready;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    unique case (r_state)
      IDLE:    if (w_accept) w_next_state = ACCESS;
      ACCESS:  w_next_state = (WAIT_CYCLES > 0) ? WAIT : CAPTURE;
      WAIT:    if (w_cnt_zero) w_next_state = CAPTURE;
      CAPTURE: w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  // The latch feeds the SRAM address/data buses directly during ACCESS.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_req <= '0;
      r_err <= 1'b0;
    end else if (w_accept) begin
      r_req <= w_req_in;
      r_err <= w_err_in;
    end
  end

  lc3_dmem_wait_cnt u_wait_cnt (
    .clock      (clock),
    .reset      (reset),
    .i_load     (r_state == ACCESS),
    .i_load_val (CNT_LOAD),
    .i_en       (r_state == WAIT),
    .o_zero     (w_cnt_zero)
  );

  // Outputs are registered, so this computes what each flop holds in the next state.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
    w_req_ready_d = r_req_ready;
    w_rsp_valid_d = 1'b0;
    w_rsp_err_d   = 1'b0;
    w_rsp_data_d  = r_rsp_data;
    w_sram_ce_d   = 1'b0;
    w_sram_we_d   = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (w_accept) begin
          w_req_ready_d = 1'b0;
          w_sram_ce_d   = ~w_err_in;
          w_sram_we_d   = ~w_err_in & ~dmem_rd;
        end
      end
      CAPTURE: begin
        w_req_ready_d = 1'b1;
        w_rsp_valid_d = 1'b1;
        w_rsp_err_d   = r_err;
        if (r_req.rd) w_rsp_data_d = r_err ? '0 : sram_rdata;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_req_ready <= 1'b1;
      r_rsp_valid <= 1'b0;
      r_rsp_err   <= 1'b0;
      r_rsp_data  <= '0;
      r_sram_ce   <= 1'b0;
      r_sram_we   <= 1'b0;
    end else begin
      r_req_ready <= w_req_ready_d;
      r_rsp_valid <= w_rsp_valid_d;
      r_rsp_err   <= w_rsp_err_d;
      r_rsp_data  <= w_rsp_data_d;
      r_sram_ce   <= w_sram_ce_d;
      r_sram_we   <= w_sram_we_d;
    end
  end

  assign req_ready     = r_req_ready;
  assign rsp_valid     = r_rsp_valid;
  assign complete_data = r_rsp_valid;
  assign rsp_err       = r_rsp_err;
  assign rsp_data      = r_rsp_data;
  assign sram_ce       = r_sram_ce;
  assign sram_we       = r_sram_we;
  assign sram_addr     = r_req.addr;
  assign sram_wdata    = r_req.din;

endmodule

// File: doc/lc3_dmem_ctrl.md
Name: lc3_dmem_ctrl

Overview:
- Data-memory controller directly downstream of the LC3 MemAccess stage.
- Consumes the MemAccess outputs (address, write data, read/write select) through a valid/ready handshake.
- Sequences each access onto a synchronous single-port SRAM with configurable wait states, then returns read data plus a one-cycle completion pulse (complete_data) to MemAccess/Controller.
- One access outstanding at a time.

Parameters:
- WAIT_CYCLES, 0, extra SRAM wait cycles between address phase and data capture (0..15).
- ADDR_W_EFF, 16, implemented address bits; any access with dmem_addr[15:ADDR_W_EFF] != 0 is out of range (ADDR_W_EFF=16 means every address is in range).

Ports:
- clock  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high
- req_valid  in  1  MemAccess request valid
- req_ready  out  1  controller can accept a request
- dmem_addr  in  16  access address
- dmem_din  in  16  write data
- dmem_rd  in  1  1=read, 0=write
- rsp_valid  out  1  one-cycle response pulse
- rsp_data  out  16  read data (held until next read response)
- rsp_err  out  1  out-of-range flag, valid with rsp_valid
- complete_data  out  1  equals rsp_valid; LC3 controller handshake
- sram_ce  out  1  SRAM chip enable
- sram_we  out  1  SRAM write enable
- sram_addr  out  16  SRAM address
- sram_wdata  out  16  SRAM write data
- sram_rdata  in  16  SRAM read data, valid 1+WAIT_CYCLES cycles after the ce cycle

Behaviour:
- All outputs are registered.
- Reset values:
  - req_ready=1.
  - rsp_valid, rsp_err, complete_data, sram_ce, sram_we = 0.
  - rsp_data, sram_addr, sram_wdata = 16'h0000.
  - State = IDLE, wait counter = 0.
- FSM states:
  - IDLE:
    - req_ready=1.
    - When req_valid&req_ready are sampled at edge N: latch addr, din, rd; compute the range error; go to ACCESS.
    - req_ready drops at N.
  - ACCESS (1 cycle):
    - In range: sram_ce=1, sram_we=~rd, sram_addr/sram_wdata driven from the latch.
    - Out of range: sram_ce=0, sram_we=0.
    - Next state is WAIT if WAIT_CYCLES>0, else CAPTURE.
    - Counter loads WAIT_CYCLES-1.
  - WAIT:
    - sram_ce=0, sram_we=0.
    - Counter decrements each cycle; on 0, go to CAPTURE.
    - Occupies exactly WAIT_CYCLES cycles.
  - CAPTURE (1 cycle):
    - At the closing edge:
      - In-range read: rsp_data<=sram_rdata.
      - Out-of-range read: rsp_data<=16'h0000.
      - Write: rsp_data unchanged.
    - rsp_valid<=1, complete_data<=1, rsp_err<=range error, req_ready<=1.
    - Go to IDLE.
- Latency:
  - Request accepted at edge N: rsp_valid high in cycle N+3+WAIT_CYCLES, for exactly 1 cycle.
  - Throughput: one access per 3+WAIT_CYCLES cycles.
- Back-to-back:
  - req_ready is high in the same cycle as rsp_valid.
  - A request sampled then is accepted with no bubble beyond the stated throughput.
- No request is accepted in ACCESS/WAIT/CAPTURE.
- req_valid while not ready is ignored; the source holds its request.
- rsp_err is cleared to 0 the cycle after rsp_valid, together with rsp_valid.
- Writes assert sram_we only in the ACCESS cycle, never more than once per request.
- Out-of-range requests never assert sram_ce.
- Reset mid-operation (any state):
  - Next cycle: IDLE with reset values.
  - Pending access is abandoned; no rsp_valid is emitted.
  - An in-flight write whose ACCESS cycle already occurred is not undone.
- Reset and req_valid in the same cycle: reset wins; the request is not accepted.

Decomposition:
- Package lc3_dmem_pkg holds:
  - State enum {IDLE, ACCESS, WAIT, CAPTURE}.
  - WORD_W=16, ADDR_W=16.
  - Request struct {addr, din, rd}.
- One sub-module: lc3_dmem_wait_cnt, a 4-bit loadable down-counter with load, enable and zero flag.

Test Plan:
1. Read, WAIT_CYCLES=0: SRAM[16'h3010]=16'hBEEF, request accepted at edge 10 -> sram_ce=1/sram_we=0 in cycle 11; rsp_valid=complete_data=1, rsp_data=16'hBEEF in cycle 13 only.
2. Write then read, WAIT_CYCLES=2: write 16'h1234 to 16'h4000, then read 16'h4000 -> single sram_we pulse; each rsp_valid 5 cycles after accept; read returns 16'h1234, rsp_err=0.
3. Back-to-back reads, req_valid held high, WAIT_CYCLES=0: reads of 16'h0001, 16'h0002 -> accepts every 3 cycles; responses in order with the matching data.
4. Out of range, ADDR_W_EFF=12: read 16'h1000 -> sram_ce never asserted; rsp_valid with rsp_err=1, rsp_data=16'h0000 at normal latency.
5. Reset in WAIT, WAIT_CYCLES=3: assert reset one cycle after ACCESS -> no rsp_valid; req_ready=1 the cycle after reset; the next read completes normally.
6. Reset and req_valid in the same cycle -> request not accepted, sram_ce stays 0.
